// File: rtl/puf_eval_ctrl_if.sv
// Wishbone classic slave bundle for the PUF evaluation controller.
interface puf_eval_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Bistable-ring PUF evaluation engine: challenge register, reset/settle
// sequencing, VOTES-fold sampling with per-bit majority and instability mask.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ring held in reset, waiting for a start write
// S_ARM     | ring held in reset for RST_CYC cycles
// S_SETTLE  | ring released, settling for SETTLE cycles
// S_SAMPLE  | one cycle: accumulate synced response into per-bit counters
// S_RESOLVE | one cycle: majority/instability computed, done + irq raised
module puf_eval_ctrl #(
  parameter int BITS    = 32,
  parameter int VOTES   = 5,
  parameter int RST_CYC = 2,
  parameter int SETTLE  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  puf_eval_ctrl_if.slave    wbs,
  output logic [BITS-1:0]   puf_challenge_o,
  output logic              puf_reset_o,
  input  logic [BITS-1:0]   puf_rsp_i,
  output logic              busy_o,
  output logic              done_irq_o,
  output logic              resp_parity_o
);

  localparam int CW   = $clog2(VOTES + 1);
  localparam int TMAX = (RST_CYC > SETTLE) ? RST_CYC : SETTLE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SETTLE, S_SAMPLE, S_RESOLVE
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q [BITS];
  logic [CW-1:0]     cnt_d [BITS];
  logic [BITS-1:0]   chal_q, chal_d;
  logic [BITS-1:0]   resp_q, resp_d;
  logic [BITS-1:0]   unst_q, unst_d;
  logic [BITS-1:0]   sync1_q, sync1_d;
  logic [BITS-1:0]   sync2_q, sync2_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              irq_q, irq_d;
  logic              par_q, par_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;

  logic              req, wr_fire, start_ok, clr_req;
  logic              sample_en, resolve_en, ring_rst;
  logic [1:0]        reg_sel;
  logic [31:0]       byte_mask;
  logic              unused_bus_bits;

  // Bus decode: a write takes effect on its ack cycle, while the master still holds it.
  assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign reg_sel   = wbs.wbs_adr_i[3:2];
  assign wr_fire   = ack_q & req & wbs.wbs_we_i;
  assign start_ok  = wr_fire & (reg_sel == 2'd0) & wbs.wbs_dat_i[0] & ~busy_q;
  assign clr_req   = wr_fire & (reg_sel == 2'd0) & wbs.wbs_dat_i[1];
  assign byte_mask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                      {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
  assign unused_bus_bits = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                             wbs.wbs_dat_i, wbs.wbs_sel_i};

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; timers are down-counters that hand over at zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_ARM;
      S_ARM:     if (tmr_q == '0) state_d = S_SETTLE;
      S_SETTLE:  if (tmr_q == '0) state_d = S_SAMPLE;
      S_SAMPLE:  state_d = (idx_q == CW'(VOTES - 1)) ? S_RESOLVE : S_ARM;
      S_RESOLVE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State-decoded controls: the ring only runs during SETTLE and SAMPLE.
  always_comb begin
    ring_rst   = 1'b1;
    sample_en  = 1'b0;
    resolve_en = 1'b0;
    case (state_q)
      S_SETTLE:  ring_rst   = 1'b0;
      S_SAMPLE:  begin ring_rst = 1'b0; sample_en = 1'b1; end
      S_RESOLVE: resolve_en = 1'b1;
      default:   ring_rst   = 1'b1;
    endcase
  end

  // Datapath next values: bus registers, timer, vote accumulation and resolution.
  always_comb begin
    ack_d   = req & ~ack_q;
    rdat_d  = rdat_q;
    if (req & ~ack_q) begin
      rdat_d = '0;
      case (reg_sel)
        2'd0:    rdat_d[1:0]      = {done_q, busy_q};
        2'd1:    rdat_d[BITS-1:0] = chal_q;
        2'd2:    rdat_d[BITS-1:0] = resp_q;
        default: rdat_d[BITS-1:0] = unst_q;
      endcase
    end

    chal_d = chal_q;
    if (wr_fire && reg_sel == 2'd1 && !busy_q)
      chal_d = (chal_q & ~byte_mask[BITS-1:0]) | (wbs.wbs_dat_i[BITS-1:0] & byte_mask[BITS-1:0]);

    busy_d = busy_q;
    if (start_ok)        busy_d = 1'b1;
    else if (resolve_en) busy_d = 1'b0;

    // Start beats a same-cycle clear; completion beats a same-cycle clear.
    done_d = done_q;
    if (start_ok)        done_d = 1'b0;
    else if (resolve_en) done_d = 1'b1;
    else if (clr_req)    done_d = 1'b0;

    irq_d = resolve_en;

    tmr_d = tmr_q;
    if (state_q != S_ARM && state_d == S_ARM)              tmr_d = TW'(RST_CYC - 1);
    else if (state_q != S_SETTLE && state_d == S_SETTLE)   tmr_d = TW'(SETTLE - 1);
    else if (tmr_q != '0)                                  tmr_d = tmr_q - TW'(1);

    idx_d = idx_q;
    cnt_d = cnt_q;
    if (start_ok) begin
      idx_d = '0;
      for (int i = 0; i < BITS; i++) cnt_d[i] = '0;
    end else if (sample_en) begin
      idx_d = idx_q + CW'(1);
      for (int i = 0; i < BITS; i++) cnt_d[i] = cnt_q[i] + CW'(sync2_q[i]);
    end

    resp_d = resp_q;
    unst_d = unst_q;
    if (resolve_en) begin
      for (int i = 0; i < BITS; i++) begin
        resp_d[i] = (cnt_q[i] > CW'(VOTES / 2));
        unst_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != CW'(VOTES));
      end
    end

    par_d   = ^resp_q;
    sync1_d = puf_rsp_i;
    sync2_d = sync1_q;
  end

  // Datapath registers; reset aborts any measurement and clears results.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmr_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < BITS; i++) cnt_q[i] <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      unst_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      par_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      unst_q  <= unst_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      par_q   <= par_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wbs.wbs_ack_o   = ack_q;
  assign wbs.wbs_dat_o   = rdat_q;
  assign puf_challenge_o = chal_q;
  assign puf_reset_o     = ring_rst;
  assign busy_o          = busy_q;
  assign done_irq_o      = irq_q;
  assign resp_parity_o   = par_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: default instance plus a reduced
// instance (BITS=16, VOTES=1, RST_CYC=1, SETTLE=1) sharing one bus.
module tb_puf_eval_ctrl;

  typedef struct {
    logic [31:0] resp;
    logic [31:0] unst;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb0 = 1'b0, wb_stb1 = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_adr = '0, wb_dw = '0;
  logic [31:0] rsp0 = '0;
  logic [15:0] rsp1 = '0;

  logic [31:0] chal0;
  logic [15:0] chal1;
  logic        pres0, pres1, busy0, busy1, irq0, irq1, par0, par1;
  logic        ack0, ack1;
  logic [31:0] dr0, dr1;

  int   cnum = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [31:0] chal_exp = '0;
  exp_t sb[$];

  puf_eval_ctrl_if wb0 ();
  puf_eval_ctrl_if wb1 ();

  assign wb0.wbs_cyc_i = wb_cyc;
  assign wb0.wbs_stb_i = wb_stb0;
  assign wb0.wbs_we_i  = wb_we;
  assign wb0.wbs_sel_i = wb_sel;
  assign wb0.wbs_adr_i = wb_adr;
  assign wb0.wbs_dat_i = wb_dw;
  assign wb1.wbs_cyc_i = wb_cyc;
  assign wb1.wbs_stb_i = wb_stb1;
  assign wb1.wbs_we_i  = wb_we;
  assign wb1.wbs_sel_i = wb_sel;
  assign wb1.wbs_adr_i = wb_adr;
  assign wb1.wbs_dat_i = wb_dw;
  assign ack0 = wb0.wbs_ack_o;
  assign dr0  = wb0.wbs_dat_o;
  assign ack1 = wb1.wbs_ack_o;
  assign dr1  = wb1.wbs_dat_o;

  puf_eval_ctrl dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wb0),
    .puf_challenge_o(chal0), .puf_reset_o(pres0), .puf_rsp_i(rsp0),
    .busy_o(busy0), .done_irq_o(irq0), .resp_parity_o(par0)
  );

  puf_eval_ctrl #(.BITS(16), .VOTES(1), .RST_CYC(1), .SETTLE(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wb1),
    .puf_challenge_o(chal1), .puf_reset_o(pres1), .puf_rsp_i(rsp1),
    .busy_o(busy1), .done_irq_o(irq1), .resp_parity_o(par1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnum <= cnum + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  function automatic logic f_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic logic f_irq(input int d);
    return (d == 0) ? irq0 : irq1;
  endfunction

  function automatic logic f_par(input int d);
    return (d == 0) ? par0 : par1;
  endfunction

  task automatic set_rsp(input int d, input logic [31:0] v);
    if (d == 0) rsp0 = v;
    else        rsp1 = v[15:0];
  endtask

  // One Wishbone classic transfer; t is the cycle in which ack was seen.
  task automatic bus(input int d, input logic w, input logic [1:0] a, input logic [31:0] v,
                     input logic [3:0] s, output logic [31:0] rdv, output int t);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_we = w; wb_adr = {28'd0, a, 2'b00}; wb_dw = v; wb_sel = s;
    if (d == 0) wb_stb0 = 1'b1; else wb_stb1 = 1'b1;
    t = -1; rdv = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if ((d == 0) ? ack0 : ack1) begin
        t = cnum; rdv = (d == 0) ? dr0 : dr1; break;
      end
    end
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb0 = 1'b0; wb_stb1 = 1'b0; wb_we = 1'b0;
    if (t < 0) begin
      $display("FAIL bus_timeout: no ack from dut%0d adr %0d", d, a);
      $fatal(1, "bus hang");
    end
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v, output int t);
    logic [31:0] dummy;
    bus(d, 1'b1, a, v, 4'hF, dummy, t);
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
    int t;
    bus(d, 1'b0, a, 32'd0, 4'hF, v, t);
  endtask

  // Waits for the irq of a measurement started (acked) in cycle t0, stepping
  // the per-vote response pattern at the start of each vote window.
  task automatic wait_irq(input int d, input int t0, input int nv, input int vlen,
                          input logic [31:0] pat [5], output int got, output int early);
    int k;
    k = 1; got = -1; early = 0;
    for (int c = 0; c < 200; c++) begin
      if (k < nv && cnum >= t0 + 1 + k * vlen) begin
        set_rsp(d, pat[k]);
        k++;
      end
      @(negedge clk);
      if (f_irq(d)) begin got = cnum; break; end
      if (!f_busy(d)) early = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic measure(input int d, input int nv, input int vlen,
                         input logic [31:0] pat [5], input string nm);
    exp_t e;
    logic [31:0] m, r;
    int t, got, early, ones;
    m = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    e.resp = '0; e.unst = '0;
    for (int b = 0; b < 32; b++) begin
      ones = 0;
      for (int k = 0; k < nv; k++) ones += int'(pat[k][b]);
      if (m[b]) begin
        e.resp[b] = (ones > nv / 2);
        e.unst[b] = (ones != 0) && (ones != nv);
      end
    end
    set_rsp(d, pat[0]);
    repeat (3) @(posedge clk);
    wr(d, 2'd0, 32'h1, t);
    e.done_cyc = t + 1 + nv * vlen + 1;
    sb.push_back(e);
    wait_irq(d, t, nv, vlen, pat, got, early);
    e = sb.pop_front();
    n_assert++;
    if (got !== e.done_cyc) begin
      n_fail++; $display("FAIL %s_done_cycle: got %0d expected %0d", nm, got, e.done_cyc);
    end
    n_assert++;
    if (early !== 0) begin
      n_fail++; $display("FAIL %s_busy_early: busy dropped before irq (flag %0d)", nm, early);
    end
    n_assert++;
    if (f_busy(d) !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_at_done: got %b expected 0", nm, f_busy(d));
    end
    @(posedge clk); #1; @(negedge clk);
    n_assert++;
    if (f_irq(d) !== 1'b0) begin
      n_fail++; $display("FAIL %s_irq_width: irq still %b one cycle later, expected 0", nm, f_irq(d));
    end
    n_assert++;
    if (f_par(d) !== ^e.resp) begin
      n_fail++; $display("FAIL %s_parity: got %b expected %b", nm, f_par(d), ^e.resp);
    end
    rd(d, 2'd2, r);
    n_assert++;
    if (r !== e.resp) begin
      n_fail++; $display("FAIL %s_response: got %h expected %h", nm, r, e.resp);
    end
    rd(d, 2'd3, r);
    n_assert++;
    if (r !== e.unst) begin
      n_fail++; $display("FAIL %s_unstable: got %h expected %h", nm, r, e.unst);
    end
    rd(d, 2'd0, r);
    n_assert++;
    if (r !== 32'h2) begin
      n_fail++; $display("FAIL %s_ctrl_done: got %h expected 00000002", nm, r);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wr(0, 2'd1, 32'hDEAD_BEEF, t);
    rd(0, 2'd1, r);
    set_rsp(0, 32'h0);
    wr(0, 2'd0, 32'h1, t);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if ({busy0, pres0} !== 2'b10) begin
      n_fail++; $display("FAIL pre_reset_state: busy/puf_reset got %b expected 10", {busy0, pres0});
    end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({busy0, irq0, par0, ack0} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: busy/irq/par/ack got %b expected 0000", {busy0, irq0, par0, ack0});
    end
    n_assert++;
    if (pres0 !== 1'b1 || pres1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_puf_reset: got %b%b expected 11", pres0, pres1);
    end
    n_assert++;
    if (chal0 !== 32'h0 || dr0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs_out: challenge %h dat_o %h expected 0 and 0", chal0, dr0);
    end
    @(negedge clk); #2 rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(0, a[1:0], r);
      n_assert++;
      if (r !== 32'h0) begin
        n_fail++; $display("FAIL reset_read_reg%0d: got %h expected 00000000", a, r);
      end
    end
    chal_exp = '0;
  endtask

  task automatic test_regs();
    logic [31:0] r;
    int t, acks;
    bus(0, 1'b1, 2'd1, 32'hA5A5_0F0F, 4'b0011, r, t);
    n_assert++;
    if (ack0 !== 1'b0) begin
      n_fail++; $display("FAIL ack_width_write: ack %b one cycle after ack, expected 0", ack0);
    end
    chal_exp = 32'h0000_0F0F;
    rd(0, 2'd1, r);
    n_assert++;
    if (r !== chal_exp) begin
      n_fail++; $display("FAIL challenge_bytesel: got %h expected %h", r, chal_exp);
    end
    n_assert++;
    if (chal0 !== chal_exp) begin
      n_fail++; $display("FAIL challenge_port: got %h expected %h", chal0, chal_exp);
    end
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb0 = 1'b1; wb_we = 1'b0; wb_adr = 32'h4; wb_sel = 4'hF;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack0) begin
        acks++;
        n_assert++;
        if (dr0 !== chal_exp) begin
          n_fail++; $display("FAIL held_read_data: got %h expected %h", dr0, chal_exp);
        end
      end
    end
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb0 = 1'b0;
    n_assert++;
    if (acks !== 4) begin
      n_fail++; $display("FAIL held_ack_count: got %0d expected 4", acks);
    end
    wr(1, 2'd1, 32'hFFFF_FFFF, t);
    rd(1, 2'd1, r);
    n_assert++;
    if (r !== 32'h0000_FFFF) begin
      n_fail++; $display("FAIL narrow_challenge: got %h expected 0000ffff", r);
    end
    n_assert++;
    if (chal1 !== 16'hFFFF) begin
      n_fail++; $display("FAIL narrow_challenge_port: got %h expected ffff", chal1);
    end
    wr(0, 2'd2, 32'hFFFF_FFFF, t);
    rd(0, 2'd2, r);
    n_assert++;
    if (r !== 32'h0) begin
      n_fail++; $display("FAIL ro_write_ignored: got %h expected 00000000", r);
    end
  endtask

  task automatic test_stable();
    logic [31:0] pat [5];
    logic [31:0] r;
    int t;
    for (int k = 0; k < 5; k++) pat[k] = 32'h1234_5678;
    measure(0, 5, 11, pat, "stable");
    n_assert++;
    if (par0 !== 1'b1) begin
      n_fail++; $display("FAIL stable_parity_const: got %b expected 1", par0);
    end
    wr(0, 2'd0, 32'h2, t);
    rd(0, 2'd0, r);
    n_assert++;
    if (r !== 32'h0) begin
      n_fail++; $display("FAIL done_clear: ctrl got %h expected 00000000", r);
    end
  endtask

  task automatic test_majority();
    logic [31:0] pat [5];
    logic [31:0] base;
    base = 32'h1234_5678;
    pat[0] = base ^ 32'h1; pat[1] = base ^ 32'h1; pat[2] = base; pat[3] = base; pat[4] = base;
    measure(0, 5, 11, pat, "flip2");
    pat[0] = base ^ 32'h1; pat[1] = base; pat[2] = base ^ 32'h1; pat[3] = base; pat[4] = base ^ 32'h1;
    measure(0, 5, 11, pat, "flip3");
    for (int k = 0; k < 5; k++) pat[k] = $urandom;
    measure(0, 5, 11, pat, "random");
  endtask

  task automatic test_busy_lockout();
    logic [31:0] pat [5];
    logic [31:0] r;
    exp_t e;
    int t, t2, got, early, extra;
    for (int k = 0; k < 5; k++) pat[k] = 32'h0F0F_00FF;
    set_rsp(0, pat[0]);
    repeat (3) @(posedge clk);
    wr(0, 2'd0, 32'h3, t);
    e.resp = 32'h0F0F_00FF; e.unst = '0; e.done_cyc = t + 57;
    sb.push_back(e);
    rd(0, 2'd0, r);
    n_assert++;
    if (r !== 32'h1) begin
      n_fail++; $display("FAIL start_and_clear: ctrl got %h expected 00000001", r);
    end
    wr(0, 2'd1, 32'hFFFF_FFFF, t2);
    wr(0, 2'd0, 32'h1, t2);
    wait_irq(0, t, 5, 11, pat, got, early);
    e = sb.pop_front();
    n_assert++;
    if (got !== e.done_cyc) begin
      n_fail++; $display("FAIL lockout_done_cycle: got %0d expected %0d", got, e.done_cyc);
    end
    n_assert++;
    if (early !== 0) begin
      n_fail++; $display("FAIL lockout_busy_early: busy dropped before irq");
    end
    extra = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1; @(negedge clk);
      if (irq0) extra++;
    end
    n_assert++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL lockout_extra_irq: got %0d extra irqs expected 0", extra);
    end
    rd(0, 2'd1, r);
    n_assert++;
    if (r !== chal_exp || chal0 !== chal_exp) begin
      n_fail++; $display("FAIL lockout_challenge: reg %h port %h expected %h", r, chal0, chal_exp);
    end
    rd(0, 2'd2, r);
    n_assert++;
    if (r !== e.resp) begin
      n_fail++; $display("FAIL lockout_response: got %h expected %h", r, e.resp);
    end
  endtask

  task automatic test_abort();
    logic [31:0] pat [5];
    logic [31:0] r;
    int t, irqs;
    set_rsp(0, 32'h3C3C_3C3C);
    wr(0, 2'd0, 32'h1, t);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cnum >= t + 30) break;
    end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({busy0, irq0, pres0} !== 3'b001) begin
      n_fail++; $display("FAIL abort_outputs: busy/irq/puf_reset got %b expected 001", {busy0, irq0, pres0});
    end
    @(negedge clk); #2 rst = 1'b0;
    chal_exp = '0;
    irqs = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (irq0) irqs++;
    end
    n_assert++;
    if (irqs !== 0) begin
      n_fail++; $display("FAIL abort_irq: got %0d irqs expected 0", irqs);
    end
    rd(0, 2'd2, r);
    n_assert++;
    if (r !== 32'h0) begin
      n_fail++; $display("FAIL abort_response: got %h expected 00000000", r);
    end
    rd(0, 2'd0, r);
    n_assert++;
    if (r !== 32'h0) begin
      n_fail++; $display("FAIL abort_ctrl: got %h expected 00000000", r);
    end
    for (int k = 0; k < 5; k++) pat[k] = 32'h3C3C_3C3C;
    measure(0, 5, 11, pat, "after_abort");
  endtask

  task automatic test_small_params();
    logic [31:0] pat [5];
    pat[0] = 32'hFFFF_A5A5; pat[1] = '0; pat[2] = '0; pat[3] = '0; pat[4] = '0;
    measure(1, 1, 3, pat, "small");
    pat[0] = 32'h0000_0001;
    measure(1, 1, 3, pat, "small2");
  endtask

  initial begin
    test_reset();
    test_regs();
    test_stable();
    test_majority();
    test_busy_lockout();
    test_abort();
    test_small_params();
    n_assert++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Wishbone-controlled evaluation engine for a bistable-ring PUF core. It owns the challenge register, drives the PUF reset/settle sequence, and samples the response `VOTES` times. It resolves each response bit by majority vote and flags bits that disagreed across samples. It sits between the user-project Wishbone slave port and an external `BR_PUF` instance, replacing direct pad-driven challenges with a register-driven, repeatable measurement.

## Interface

**Parameters**
- `BITS`, 32: challenge/response width, 1..32. Register bits above `BITS` read 0 and are ignored on write.
- `VOTES`, 5: evaluations per measurement. Odd, 1..15.
- `RST_CYC`, 2: cycles `puf_reset_o` is held high per evaluation, ≥1.
- `SETTLE`, 8: cycles allowed for the ring to settle after reset release, ≥1.

**Ports**
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, asynchronous and active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i` in 32: address. Only `[3:2]` is decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `puf_challenge_o` out BITS: challenge to the PUF core, driven from the CHALLENGE register.
- `puf_reset_o` out 1: PUF ring reset.
- `puf_rsp_i` in BITS: raw PUF response. Treated as asynchronous and double-flopped internally.
- `busy_o` out 1: measurement in progress.
- `done_irq_o` out 1: one-cycle pulse when a measurement completes.
- `resp_parity_o` out 1: XOR of the RESPONSE register, intended for a pad.

## Operation

- **Register map** (`adr[3:2]`):
  - 0 CTRL: write bit0=1 to start. Read returns bit0=busy, bit1=done (sticky). Write bit1=1 to clear done.
  - 1 CHALLENGE: R/W. Byte selects honoured.
  - 2 RESPONSE: RO, majority result.
  - 3 UNSTABLE: RO, per-bit disagreement mask.
- **Wishbone handshake**:
  - `wbs_ack_o` rises the cycle after `cyc&stb` is seen with ack low, and lasts 1 cycle. A held request therefore acks every other cycle.
  - Reads are registered and valid with ack.
  - Writes to RO registers are acked and ignored.
- **FSM**: IDLE → ARM → SETTLE → SAMPLE → (ARM | RESOLVE) → IDLE.
  - IDLE: `puf_reset_o`=1. A start write on the ack cycle moves to ARM next cycle, clears the vote counters, clears done, and sets busy.
  - ARM: `puf_reset_o`=1 for `RST_CYC` cycles.
  - SETTLE: `puf_reset_o`=0 for `SETTLE` cycles.
  - SAMPLE: 1 cycle. Per-bit counter[i] += synced `puf_rsp_i[i]`; vote index increments. If the index reaches `VOTES`, go to RESOLVE, otherwise ARM.
  - RESOLVE: 1 cycle.
    - RESPONSE[i] = (counter[i] > VOTES/2).
    - UNSTABLE[i] = (counter[i] != 0 && counter[i] != VOTES).
    - Sets done, pulses `done_irq_o`, clears busy, returns to IDLE.
- **Widths**: per-bit counters are `$clog2(VOTES+1)` bits, so saturation is impossible. The vote index uses the same width.
- **While busy**:
  - CHALLENGE writes are acked and ignored.
  - A start write is ignored.
  - The done clear is honoured.
- **Reset value** of every output and register is 0, except `puf_reset_o`=1. Reset mid-measurement aborts immediately to IDLE with no irq, and RESPONSE/UNSTABLE are cleared.

## Timing

- Start acked in cycle T → first ARM cycle is T+1.
- RESOLVE occurs at T+1+VOTES·(RST_CYC+SETTLE+1).
  - With defaults: T+56.
  - RESPONSE, UNSTABLE, done and `busy_o`=0 are visible at T+57; `done_irq_o` is high during T+57 only.
- `resp_parity_o` updates the cycle after RESPONSE changes.
- Sampling timing: the response used in SAMPLE is the value present 2 cycles earlier, i.e. the last two SETTLE cycles, because of the synchroniser.
- Same-cycle start and done-clear: start wins, and done is 0.

## Test plan

- **Reset values**: async reset asserted mid-cycle → all outputs 0 immediately, `puf_reset_o`=1; register reads return 0.
- **Register access**:
  - Write CHALLENGE 0xA5A50F0F with sel=4'b0011, then read → 0x00000F0F.
  - `puf_challenge_o` matches.
  - Each ack is exactly 1 cycle.
- **Stable measurement**: model returns constant 0x12345678 → done at T+57, RESPONSE=0x12345678, UNSTABLE=0, `resp_parity_o`=1, one irq pulse.
- **Majority vote**:
  - bit0 flipped in 2 of 5 samples → RESPONSE bit0=0, UNSTABLE=0x00000001.
  - bit0 flipped in 3 of 5 → RESPONSE bit0=1, UNSTABLE=0x00000001.
- **Busy lockout**: during a measurement, write CHALLENGE 0xFFFFFFFF and start again → CHALLENGE unchanged, single done at T+57, `busy_o` never drops early.
- **Abort and parameters**:
  - Reset at T+30 → IDLE, no irq, RESPONSE=0.
  - A fresh start then completes normally.
  - Repeat with `VOTES`=1, `RST_CYC`=1, `SETTLE`=1 → done at T+5.
